// File: rtl/div_iter_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU with RISC-V divide-by-zero and overflow results.
// Optional DIV_FAST_SPECIAL_EN: divide-by-zero/overflow skip the iteration phase (identical results, shorter latency).
module div_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             div_on_i,
    input  logic             signed_A_i,
    input  logic             signed_B_i,
    input  logic             upper_rem_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH:0]   rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] dsr_reg;
    logic [WIDTH-1:0] rs1_reg;
    logic [WIDTH-1:0] result_reg;
    logic [CW-1:0]    count_reg;
    logic             neg_q_reg, neg_r_reg, dz_reg, ovf_reg, upper_rem_reg;

    // Request decode, evaluated on the live inputs for the acceptance edge
    logic             accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             in_dz, in_ovf;

    assign accept = start_i & div_on_i;
    assign a_neg  = signed_A_i & rs1_i[WIDTH-1];
    assign b_neg  = signed_B_i & rs2_i[WIDTH-1];
    assign a_mag  = a_neg ? (~rs1_i + ONE) : rs1_i;
    assign b_mag  = b_neg ? (~rs2_i + ONE) : rs2_i;
    assign in_dz  = (rs2_i == '0);
    assign in_ovf = signed_A_i & signed_B_i & (rs1_i == MIN_INT) & (rs2_i == '1);

    // One restoring step: shift {rem, quo} left and try subtracting the divisor
    logic [WIDTH:0] rem_shift, trial;

    assign rem_shift = {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, dsr_reg};

    // Sign fix-up and special-case override of the final value
    logic [WIDTH-1:0] quo_final, rem_final, fix_value;

    always_comb begin
        quo_final = neg_q_reg ? (~quo_reg + ONE) : quo_reg;
        rem_final = neg_r_reg ? (~rem_reg[WIDTH-1:0] + ONE) : rem_reg[WIDTH-1:0];
        if (dz_reg) begin
            quo_final = '1;
            rem_final = rs1_reg;
        end else if (ovf_reg) begin
            quo_final = MIN_INT;
            rem_final = '0;
        end
        fix_value = upper_rem_reg ? rem_final : quo_final;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
`ifdef DIV_FAST_SPECIAL_EN
                    state_next = (in_dz | in_ovf) ? FIX : CALC;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC:    if (count_reg == LAST) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rem_reg       <= '0;
            quo_reg       <= '0;
            dsr_reg       <= '0;
            rs1_reg       <= '0;
            result_reg    <= '0;
            count_reg     <= '0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            dz_reg        <= 1'b0;
            ovf_reg       <= 1'b0;
            upper_rem_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        rem_reg       <= '0;
                        quo_reg       <= a_mag;
                        dsr_reg       <= b_mag;
                        rs1_reg       <= rs1_i;
                        count_reg     <= '0;
                        neg_q_reg     <= a_neg ^ b_neg;
                        neg_r_reg     <= a_neg;
                        dz_reg        <= in_dz;
                        ovf_reg       <= in_ovf;
                        upper_rem_reg <= upper_rem_i;
                    end
                end
                CALC: begin
                    if (!trial[WIDTH]) begin
                        rem_reg <= trial;
                        quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_reg <= rem_shift;
                        quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
                    end
                    count_reg <= count_reg + CW'(1);
                end
                FIX: begin
                    result_reg <= fix_value;
                end
                default: ;
            endcase
        end
    end

    assign busy_o   = (state_reg == CALC) || (state_reg == FIX);
    assign done_o   = (state_reg == DONE);
    assign result_o = result_reg;

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed-vector bench for div_iter_unit (WIDTH = 32): results, latency, handshake and reset abort.
module tb_div_iter_unit;

`ifdef DIV_FAST_SPECIAL_EN
    localparam int L_SP = 2;
`else
    localparam int L_SP = 34;
`endif
    localparam int L_NORM = 34;

    logic        clk;
    logic        rst_n;
    logic        start, div_on, signed_a, signed_b, upper_rem;
    logic [31:0] rs1, rs2;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    div_iter_unit #(.WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .div_on_i    (div_on),
        .signed_A_i  (signed_a),
        .signed_B_i  (signed_b),
        .upper_rem_i (upper_rem),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .busy_o      (busy),
        .done_o      (done),
        .result_o    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end else begin
            $display("ok   %s: 0x%08h", tag, observed);
        end
    endtask

    // Issue one op, count cycles from the acceptance edge (cycle 1 = first cycle after it) until done
    task automatic run_op(input string tag, input logic sa, input logic sb, input logic ur,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input bit disturb);
        int cyc;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1; div_on = 1'b1;
        signed_a = sa; signed_b = sb; upper_rem = ur;
        rs1 = a; rs2 = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        check({tag, " busy"}, {31'b0, busy}, 32'd1);
        while (!done && cyc < 200) begin
            if (disturb && (cyc == 5 || cyc == 20)) begin
                start = 1'b1; rs1 = 32'd1000; rs2 = 32'd3; upper_rem = ~ur;
                signed_a = ~sa;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " result"}, result, exp_res);
        check({tag, " busy@done"}, {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, " done pulse"}, {31'b0, done}, 32'd0);
        check({tag, " result hold"}, result, exp_res);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; div_on = 1'b0;
        signed_a = 1'b0; signed_b = 1'b0; upper_rem = 1'b0;
        rs1 = '0; rs2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("divu 100/7",   1'b0, 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, L_NORM, 1'b0);
        run_op("remu 100%7",   1'b0, 1'b0, 1'b1, 32'd100, 32'd7, 32'd2,  L_NORM, 1'b0);
        run_op("div -7/2",     1'b1, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, L_NORM, 1'b0);
        run_op("rem -7%2",     1'b1, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, L_NORM, 1'b0);
        run_op("div 7/-2",     1'b1, 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, L_NORM, 1'b0);
        run_op("rem 7%-2",     1'b1, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, L_NORM, 1'b0);
        run_op("div -100/-7",  1'b1, 1'b1, 1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, L_NORM, 1'b0);
        run_op("rem -100%-7",  1'b1, 1'b1, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, L_NORM, 1'b0);
        run_op("divu max/1",   1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, L_NORM, 1'b0);
        run_op("divu dz",      1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, L_SP, 1'b0);
        run_op("remu dz",      1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'd0, 32'h1234_5678, L_SP, 1'b0);
        run_op("div dz",       1'b1, 1'b1, 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, L_SP, 1'b0);
        run_op("rem dz neg",   1'b1, 1'b1, 1'b1, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, L_SP, 1'b0);
        run_op("div ovf",      1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, L_SP, 1'b0);
        run_op("rem ovf",      1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, L_SP, 1'b0);
        run_op("divu ovf ops", 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, L_NORM, 1'b0);
        run_op("remu ovf ops", 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, L_NORM, 1'b0);

        // Restarts mid-operation must not disturb the op in flight
        run_op("divu restart", 1'b0, 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, L_NORM, 1'b1);

        // start without div_on is ignored
        @(negedge clk);
        start = 1'b1; div_on = 1'b0; rs1 = 32'd50; rs2 = 32'd5;
        @(posedge clk);
        #1;
        check("no div_on busy", {31'b0, busy}, 32'd0);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("no div_on idle", {31'b0, busy | done}, 32'd0);

        // Reset at cycle 10 of an op aborts it
        @(negedge clk);
        start = 1'b1; div_on = 1'b1; signed_a = 1'b0; signed_b = 1'b0; upper_rem = 1'b0;
        rs1 = 32'd999; rs2 = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort done", {31'b0, done}, 32'd0);
        check("abort result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("divu after rst", 1'b0, 1'b0, 1'b0, 32'd999, 32'd9, 32'd111, L_NORM, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Multi-cycle radix-2 restoring divider that consumes the M-extension decode controls (div_on, signed_A, signed_B, upper_rem) and the two source operands.
- Produces DIV/DIVU/REM/REMU results with RISC-V-compliant handling of divide-by-zero and signed overflow.
- Sits directly downstream of the M-instruction decoder, alongside the multiplier. Result and done go to the core writeback path.

Parameters:
- WIDTH, 32, operand and result width in bits (power of two, >= 4).

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_n_i  input  1  asynchronous, active-low reset
- start_i  input  1  request strobe; sampled only in IDLE
- div_on_i  input  1  decoder says divide op; request accepted only when start_i & div_on_i
- signed_A_i  input  1  dividend is two's complement
- signed_B_i  input  1  divisor is two's complement
- upper_rem_i  input  1  1 = return remainder, 0 = return quotient
- rs1_i  input  WIDTH  dividend
- rs2_i  input  WIDTH  divisor
- busy_o  output  1  high while an operation is in flight (CALC, FIX)
- done_o  output  1  one-cycle pulse; result_o valid in that cycle
- result_o  output  WIDTH  quotient or remainder; held until next done_o

Behaviour:
- Reset values (asynchronous, immediate on rst_n_i low): state = IDLE; busy_o = 0; done_o = 0; result_o = 0; all internal registers = 0.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - Acceptance edge A0 occurs when start_i & div_on_i are both high.
  - At A0, latch the flags and the operand magnitudes: |x| is the two's-complement negate when the matching signed flag is set and the MSB is 1.
  - At A0, latch the flags neg_q = sA&rs1[MSB] ^ sB&rs2[MSB], neg_r = sA&rs1[MSB], dz = (rs2_i == 0), ovf = sA & sB & (rs1_i == 100..0) & (rs2_i == all ones).
  - Clear the remainder accumulator, set count = 0, go to CALC.
  - start_i without div_on_i is ignored.
- CALC: one iteration per cycle.
  - Shift {rem, quo} left by 1.
  - Trial subtraction rem - |divisor| at WIDTH+1 bits.
  - If non-negative, commit the difference and set quo[0] = 1; otherwise restore.
  - After WIDTH iterations (count == WIDTH-1), go to FIX.
- FIX: compute the final value into result_o.
  - dz: quotient = all ones, remainder = original rs1.
  - ovf: quotient = 100..0, remainder = 0.
  - Otherwise: quotient negated if neg_q; remainder negated if neg_r.
  - Select via latched upper_rem. Go to DONE.
- DONE: done_o = 1 for exactly this cycle, busy_o = 0; next cycle return to IDLE.
- Latency: done_o high in cycle WIDTH+2 after the A0 edge (34 cycles for WIDTH = 32).
- A new start_i is accepted no earlier than the cycle after DONE; back-to-back throughput is one op per WIDTH+3 cycles.
- busy_o = 1 in CALC and FIX only.
- start_i, operands and flags are ignored while not in IDLE; latched values must not change mid-operation.
- Reset mid-operation aborts immediately: no done_o, result_o = 0.
- Arithmetic: the remainder accumulator is WIDTH+1 bits; all negations are modulo 2^WIDTH. signed_A/signed_B mismatch (not produced by the decoder for divide) is still handled per the flag rules above.

Optional Feature:
- Macro DIV_FAST_SPECIAL_EN.
- Defined: when dz or ovf is detected at A0, skip CALC and go directly to FIX; done_o is then high 2 cycles after A0. The normal path is unchanged.
- Undefined: special cases run the full WIDTH iterations, and FIX overrides the result; latency is uniformly WIDTH+2.
- Results are identical in both builds.

Test Plan:
- DIVU rs1 = 100, rs2 = 7, upper_rem = 0 -> done_o at cycle 34, result_o = 14; repeat with upper_rem = 1 -> result_o = 2.
- DIV/REM signed: rs1 = 0xFFFFFFF9 (-7), rs2 = 2 -> DIV = 0xFFFFFFFD (-3), REM = 0xFFFFFFFF (-1); rs1 = 7, rs2 = 0xFFFFFFFE -> DIV = 0xFFFFFFFD, REM = 1.
- Divide by zero: rs1 = 0x12345678, rs2 = 0 -> DIV/DIVU = 0xFFFFFFFF, REM/REMU = 0x12345678. Latency is 34 without DIV_FAST_SPECIAL_EN and 2 with it.
- Overflow: rs1 = 0x80000000, rs2 = 0xFFFFFFFF, signed -> DIV = 0x80000000, REM = 0; the same operands unsigned (DIVU) -> 0.
- Handshake: start_i pulsed at cycles 5 and 20 of an op with different operands -> single done_o with the first op's result. start_i with div_on_i = 0 in IDLE -> no busy_o.
- Reset: assert rst_n_i low at cycle 10 of an op -> busy_o, done_o, result_o = 0 immediately. A new op after release completes with the correct result.
